// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter: FSM encoding and
// default sizing of the byte path and transfer watchdog.
package uart_pkg;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_ACT  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 200000;

  typedef enum logic [1:0] {
    ST_IDLE      = S_IDLE,
    ST_LOAD      = S_LOAD,
    ST_WAIT_ACT  = S_WAIT_ACT,
    ST_WAIT_DONE = S_WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit at or after ptr,
// wrapping modulo NUM_REQ. Reusable by any requester/grant arbiter.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [NUM_REQ-1:0] ONE_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest offset down to ptr itself so the nearest requester wins.
  always_comb begin
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
      idx    = req[cand_s] ? cand_s : idx;
      any    = any | req[cand_s];
    end
    onehot = any ? (ONE_LSB << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers,
// with completion tracking and a watchdog that frees a stuck line.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_active,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t          state_r, state_nx_s;
  logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_nx_s;
  logic [IDX_W-1:0]    owner_r, owner_nx_s;
  logic [WD_W-1:0]     wd_cnt_r, wd_cnt_nx_s;
  logic [NUM_REQ-1:0]  grant_r, grant_nx_s;
  logic [NUM_REQ-1:0]  done_r, done_nx_s;
  logic                tx_en_r, tx_en_nx_s;
  logic [DATA_W-1:0]   tx_data_r, tx_data_nx_s;
  logic                busy_r, busy_nx_s;
  logic                timeout_r, timeout_nx_s;

  logic [NUM_REQ-1:0]  pick_onehot_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic                wd_expire_s;
  logic [WD_W-1:0]     wd_inc_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  assign wd_expire_s = (wd_cnt_r == WD_LAST);
  assign wd_inc_s    = (wd_cnt_r == {WD_W{1'b1}}) ? wd_cnt_r : wd_cnt_r + WD_W'(1);

  // Next-state and next-output logic; a tx_done always outranks watchdog expiry.
  always_comb begin
    state_nx_s   = state_r;
    rr_ptr_nx_s  = rr_ptr_r;
    owner_nx_s   = owner_r;
    wd_cnt_nx_s  = wd_cnt_r;
    grant_nx_s   = '0;
    done_nx_s    = '0;
    tx_en_nx_s   = 1'b0;
    tx_data_nx_s = tx_data_r;
    timeout_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s && !tx_active) begin
          tx_data_nx_s = req_data[pick_idx_s*DATA_W +: DATA_W];
          owner_nx_s   = pick_idx_s;
          grant_nx_s   = pick_onehot_s;
          tx_en_nx_s   = 1'b1;
          state_nx_s   = ST_LOAD;
        end else begin
          state_nx_s   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        rr_ptr_nx_s = (owner_r == IDX_LAST) ? '0 : owner_r + IDX_W'(1);
        wd_cnt_nx_s = '0;
        state_nx_s  = ST_WAIT_ACT;
      end
      ST_WAIT_ACT, ST_WAIT_DONE: begin
        if (tx_done) begin
          done_nx_s    = ONE_LSB << owner_r;
          state_nx_s   = ST_IDLE;
        end else if (wd_expire_s) begin
          timeout_nx_s = 1'b1;
          state_nx_s   = ST_IDLE;
        end else begin
          wd_cnt_nx_s  = wd_inc_s;
          if (tx_active) begin
            state_nx_s = ST_WAIT_DONE;
          end else begin
            state_nx_s = state_r;
          end
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  // State, pointer, watchdog and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      wd_cnt_r  <= '0;
      grant_r   <= '0;
      done_r    <= '0;
      tx_en_r   <= 1'b0;
      tx_data_r <= '0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      rr_ptr_r  <= rr_ptr_nx_s;
      owner_r   <= owner_nx_s;
      wd_cnt_r  <= wd_cnt_nx_s;
      grant_r   <= grant_nx_s;
      done_r    <= done_nx_s;
      tx_en_r   <= tx_en_nx_s;
      tx_data_r <= tx_data_nx_s;
      busy_r    <= busy_nx_s;
      timeout_r <= timeout_nx_s;
    end
  end

  assign grant       = grant_r;
  assign done        = done_r;
  assign tx_en       = tx_en_r;
  assign tx_data     = tx_data_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requesters and a TX_Module model are
// driven per transfer and checked against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 50;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    grant, done;
  logic             tx_en;
  logic [DW-1:0]    tx_data;
  logic             tx_active = 1'b0;
  logic             tx_done = 1'b0;
  logic             busy, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who is waiting, with which byte, and where the search starts.
  int            rr_m = 0;
  logic [NR-1:0] pend_m = '0;
  logic [DW-1:0] data_m [NR];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int rr_winner(input logic [NR-1:0] m, input int p);
    for (int k = 0; k < NR; k++) begin
      if (m[(p + k) % NR]) return (p + k) % NR;
    end
    return 0;
  endfunction

  task automatic drive_req();
    req = pend_m;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = data_m[i];
  endtask

  task automatic add_reqs(input logic [NR-1:0] m);
    for (int i = 0; i < NR; i++) begin
      if (m[i] && !pend_m[i]) begin
        pend_m[i] = 1'b1;
        data_m[i] = 8'($urandom_range(0, 255));
      end
    end
    drive_req();
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_tx_en", tx_en, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout", timeout_err, 0);
    tx_active = 1'b0;
    tx_done   = 1'b0;
    tick();
    check_eq("rst_no_done", done, 0);
    check_eq("rst_no_timeout", timeout_err, 0);
    reset = 1'b0;
    rr_m  = 0;
  endtask

  // mode: 0 normal, 1 active+done together, 2 done on expiry cycle,
  //       3 watchdog abort, 4 async reset mid-frame
  task automatic run_xfer(input int mode, input bit hold, input bit mix);
    int k, w, h;
    bit seen, en_seen;
    logic [DW-1:0] d;
    if (pend_m == '0) add_reqs(4'($urandom_range(1, 15)));
    k = 0;
    seen = 1'b0;
    while (k < 8 && !seen) begin
      tick();
      k++;
      seen = (tx_en === 1'b1);
    end
    check_eq("grant_latency", k, 1);
    if (!seen) return;
    w = rr_winner(pend_m, rr_m);
    d = data_m[w];
    check_eq("grant", grant, 1 << w);
    check_eq("tx_data", tx_data, d);
    check_eq("busy_on", busy, 1);
    check_eq("done_idle", done, 0);
    rr_m = (w + 1) % NR;
    if (!hold) pend_m[w] = 1'b0;
    if (mix && $urandom_range(0, 1) == 1) add_reqs(4'($urandom_range(0, 15)));
    else drive_req();
    tx_done = 1'($urandom_range(0, 1));
    tick();
    tx_done = 1'b0;
    check_eq("tx_en_pulse", tx_en, 0);
    check_eq("grant_pulse", grant, 0);
    check_eq("stale_done", done, 0);
    case (mode)
      0, 1: begin
        repeat ($urandom_range(0, 3)) tick();
        tx_active = 1'b1;
        if (mode == 0) begin
          repeat ($urandom_range(1, 6)) tick();
          check_eq("done_early", done, 0);
        end
        tx_done = 1'b1;
        tick();
        tx_done   = 1'b0;
        tx_active = 1'b0;
        check_eq("done", done, 1 << w);
        check_eq("busy_off", busy, 0);
        check_eq("no_timeout", timeout_err, 0);
        check_eq("tx_data_hold", tx_data, d);
      end
      2: begin
        tx_active = 1'($urandom_range(0, 1));
        repeat (TO - 1) tick();
        check_eq("done_before_expiry", done, 0);
        tx_done = 1'b1;
        tick();
        tx_done   = 1'b0;
        tx_active = 1'b0;
        check_eq("expiry_done", done, 1 << w);
        check_eq("expiry_no_timeout", timeout_err, 0);
        check_eq("expiry_busy_off", busy, 0);
      end
      3: begin
        tx_active = 1'($urandom_range(0, 1));
        k = 0;
        while (k < TO + 10 && timeout_err !== 1'b1) begin
          tick();
          k++;
        end
        check_eq("wd_cycles", k, TO);
        check_eq("wd_no_done", done, 0);
        check_eq("wd_busy_off", busy, 0);
        tx_active = 1'b1;
        if (pend_m == '0) add_reqs(4'($urandom_range(1, 15)));
        tick();
        check_eq("wd_pulse", timeout_err, 0);
        en_seen = (tx_en === 1'b1);
        h = $urandom_range(1, 4);
        repeat (h) begin
          tick();
          en_seen = en_seen | (tx_en === 1'b1);
        end
        check_eq("no_grant_while_active", en_seen, 0);
        tx_active = 1'b0;
      end
      default: begin
        tx_active = 1'b1;
        repeat ($urandom_range(2, 6)) tick();
        add_reqs(4'b0001 | 4'($urandom_range(0, 15)));
        pulse_reset();
      end
    endcase
  endtask

  initial begin
    for (int i = 0; i < NR; i++) data_m[i] = '0;
    repeat (3) tick();
    check_eq("init_grant", grant, 0);
    check_eq("init_done", done, 0);
    check_eq("init_tx_en", tx_en, 0);
    check_eq("init_tx_data", tx_data, 0);
    check_eq("init_busy", busy, 0);
    check_eq("init_timeout", timeout_err, 0);
    reset = 1'b0;

    pend_m    = 4'b0010;
    data_m[1] = 8'hA5;
    drive_req();
    run_xfer(0, 1'b0, 1'b0);

    pend_m = '0;
    drive_req();
    tick();
    pulse_reset();
    pend_m = 4'b1111;
    for (int i = 0; i < NR; i++) data_m[i] = 8'(8'h10 + i);
    drive_req();
    for (int n = 0; n < 5; n++) run_xfer(n % 2, 1'b1, 1'b0);
    pend_m = '0;
    drive_req();

    for (int n = 0; n < 40; n++) begin
      run_xfer($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (TX_Module) between NUM_REQ byte producers, e.g. the switch input path, an LED/status reporter and a debug source.
- Arbitrates round-robin, latches the winner's byte, and pulses the transmitter's TX_EN.
- Tracks TX_ACTIVE and data_sent to completion and returns a per-requester done pulse.
- A watchdog aborts a transfer that never completes, so one stuck byte cannot lock the line.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width presented to the transmitter.
- TIMEOUT_CYCLES, 200000, max clk cycles from tx_en to tx_done before abort. Must exceed one 10-bit frame at the slowest baud.

Ports:
- clk  in  1  system clock (same domain as TX_Module and uart_baud_gen).
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  req[i]=1: requester i holds a byte; held until grant[i].
- req_data  in  NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- done  out  NUM_REQ  one-cycle pulse: byte of requester i fully sent.
- tx_en  out  1  to TX_Module TX_EN; one-cycle pulse.
- tx_data  out  DATA_W  to TX_Module Tx_input; stable from tx_en until the transfer ends.
- tx_active  in  1  from TX_Module TX_ACTIVE.
- tx_done  in  1  from TX_Module data_sent, one-cycle pulse.
- busy  out  1  1 in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, reset=1): state=IDLE, grant=0, done=0, tx_en=0, tx_data=0, busy=0, timeout_err=0, rr_ptr=0, wd_cnt=0. Reset mid-transfer drops ownership silently; no done or timeout_err is issued.
- All outputs are registered.
- FSM states: IDLE, LOAD, WAIT_ACT, WAIT_DONE.
- IDLE:
  - If req != 0 and tx_active == 0: pick winner w = first set req bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register tx_data <= req_data[w], owner <= w, grant <= onehot(w), state <= LOAD.
  - If tx_active == 1 (line still busy, e.g. after an abort), no grant is issued; stay in IDLE.
- LOAD (exactly 1 cycle):
  - grant and tx_en are both high during this cycle.
  - rr_ptr <= (w+1) mod NUM_REQ; wd_cnt <= 0; next state is WAIT_ACT.
  - Latency: req sampled at edge n -> grant/tx_en high during cycle n+1.
- WAIT_ACT: waits for tx_active=1, then goes to WAIT_DONE. If tx_done=1 arrives here (active and done coincide), treat it as completion.
- WAIT_DONE: on tx_done=1: done[owner] pulses 1 cycle, state <= IDLE.
- Watchdog:
  - wd_cnt increments every cycle in WAIT_ACT and WAIT_DONE.
  - When wd_cnt == TIMEOUT_CYCLES-1 with no tx_done that cycle: timeout_err pulses, no done is issued, state <= IDLE.
  - tx_done in the same cycle as expiry counts as success.
- Counter width: wd_cnt is $clog2(TIMEOUT_CYCLES) bits; it saturates, never wraps.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Fairness: a requester that keeps req high is served at most once per NUM_REQ grants while others are requesting.
- req is ignored outside IDLE; a requester must hold req until it sees grant.
- req_data must be stable while req is high; it is sampled only at the IDLE->LOAD edge.
- A tx_done seen in IDLE or LOAD (stale pulse) is ignored.
- Minimum spacing between consecutive tx_en pulses is 3 cycles.

Decomposition:
- Shared package/include uart_pkg:
  - state encoding localparams S_IDLE=2'd0, S_LOAD=2'd1, S_WAIT_ACT=2'd2, S_WAIT_DONE=2'd3.
  - DATA_W default and TIMEOUT_CYCLES default.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, ptr. Outputs: onehot, idx, any.
  - Instantiated once; it is reusable for a future RX-side or DMA arbiter.

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'hA5 -> grant=4'b0010 and tx_en for 1 cycle, tx_data=8'hA5; a TX_Module model then raises tx_active and pulses tx_done -> done=4'b0010 for 1 cycle, busy returns to 0.
- Round-robin: req=4'b1111 held continuously with data 8'h10/11/12/13 -> grant order 0,1,2,3,0; serial bytes 10,11,12,13,10.
- Ownership: after grant to req2, raise req0 -> req0 gets no grant until done[2]. Then req0=1 and req3=1 with rr_ptr=3 -> req3 granted first.
- Watchdog: TIMEOUT_CYCLES=50, model never asserts tx_done -> timeout_err pulses exactly 50 cycles after leaving LOAD, no done.
  - Keep tx_active=1 afterwards -> no new grant until tx_active=0.
- Async reset in WAIT_DONE: pulse reset mid-frame -> all outputs 0 immediately, no done/timeout_err. Next req0 is granted first (rr_ptr=0).
- Coincident events: tx_active and tx_done asserted in the same cycle in WAIT_ACT -> done pulses once and FSM returns to IDLE. tx_done on the watchdog expiry cycle -> done only, no timeout_err.
